// File: rtl/dl_report_arbiter_pkg.sv
// Shared definitions for the deadlock report arbiter: FSM states, the width of the
// confirmed-deadlock counter and its saturation value.
package dl_report_arbiter_pkg;

    typedef logic [1:0] dl_state_t;

    localparam dl_state_t ST_IDLE    = 2'd0;
    localparam dl_state_t ST_CONFIRM = 2'd1;
    localparam dl_state_t ST_REPORT  = 2'd2;
    localparam dl_state_t ST_RECOVER = 2'd3;

    localparam int DL_CNT_W = 8;
    localparam logic [DL_CNT_W-1:0] DL_CNT_SAT = 8'd255;

    // Increment that sticks at the saturation value.
    function automatic logic [DL_CNT_W-1:0] sat_inc(input logic [DL_CNT_W-1:0] value);
        return (value == DL_CNT_SAT) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/dl_report_arbiter_lowest_bit_sel.sv
// Combinational priority encoder: finds the lowest set bit of a vector and returns
// both its index and the matching one-hot.
module dl_lowest_bit_sel #(
    parameter int WIDTH = 2,
    parameter int IDX_W = 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/dl_report_arbiter.sv
// Picks one deadlock suspect, confirms it stays suspect for CONFIRM_CYCLES cycles,
// reports it to a consumer and then clears the detect units' tokens.
module dl_report_arbiter
    import dl_report_arbiter_pkg::*;
#(
    parameter int PROC_NUM       = 2,
    parameter int CONFIRM_CYCLES = 4,
    parameter int IDX_W          = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic                dl_report_ack,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                dl_detect_out,
    output logic                dl_report_vld,
    output logic [IDX_W-1:0]    dl_report_proc,
    output logic [7:0]          dl_count
);

    localparam logic [DL_CNT_W-1:0] CONFIRM_LIM = DL_CNT_W'(CONFIRM_CYCLES);

    dl_state_t             state_reg,  state_next;
    logic [DL_CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [IDX_W-1:0]      cand_reg,   cand_next;
    logic [PROC_NUM-1:0]   origin_reg, origin_next;
    logic                  token_clear_reg, token_clear_next;
    logic                  detect_reg, detect_next;
    logic                  vld_reg,    vld_next;
    logic [IDX_W-1:0]      proc_reg,   proc_next;
    logic [DL_CNT_W-1:0]   count_reg,  count_next;

    logic [IDX_W-1:0]      sel_idx;
    logic [PROC_NUM-1:0]   sel_onehot;
    logic                  sel_any;

    dl_lowest_bit_sel #(
        .WIDTH (PROC_NUM),
        .IDX_W (IDX_W)
    ) u_sel (
        .vec    (dl_in_vec),
        .idx    (sel_idx),
        .onehot (sel_onehot),
        .any    (sel_any)
    );

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        cand_next        = cand_reg;
        origin_next      = origin_reg;
        token_clear_next = 1'b0;
        detect_next      = detect_reg;
        vld_next         = vld_reg;
        proc_next        = proc_reg;
        count_next       = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sel_any) begin
                    cand_next   = sel_idx;
                    origin_next = sel_onehot;
                    cnt_next    = 8'd1;
                    state_next  = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (dl_in_vec[cand_reg]) begin
                    if (cnt_reg < CONFIRM_LIM) begin
                        cnt_next = cnt_reg + 8'd1;
                    end else begin
                        state_next  = ST_REPORT;
                        detect_next = 1'b1;
                        vld_next    = 1'b1;
                        proc_next   = cand_reg;
                        count_next  = sat_inc(count_reg);
                    end
                end else begin
                    // Suspect vanished: drop it and let the units rebuild their tokens.
                    token_clear_next = 1'b1;
                    origin_next      = '0;
                    cnt_next         = '0;
                    state_next       = ST_IDLE;
                end
            end
            ST_REPORT: begin
                if (dl_report_ack) begin
                    state_next       = ST_RECOVER;
                    vld_next         = 1'b0;
                    detect_next      = 1'b0;
                    origin_next      = '0;
                    cnt_next         = '0;
                    token_clear_next = 1'b1;
                end
            end
            ST_RECOVER: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            cand_reg        <= '0;
            origin_reg      <= '0;
            token_clear_reg <= 1'b0;
            detect_reg      <= 1'b0;
            vld_reg         <= 1'b0;
            proc_reg        <= '0;
            count_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            cand_reg        <= cand_next;
            origin_reg      <= origin_next;
            token_clear_reg <= token_clear_next;
            detect_reg      <= detect_next;
            vld_reg         <= vld_next;
            proc_reg        <= proc_next;
            count_reg       <= count_next;
        end
    end

    assign origin         = origin_reg;
    assign token_clear    = token_clear_reg;
    assign dl_detect_out  = detect_reg;
    assign dl_report_vld  = vld_reg;
    assign dl_report_proc = proc_reg;
    assign dl_count       = count_reg;

endmodule

// File: tb/tb_dl_report_arbiter.sv
// Bench for dl_report_arbiter: two instances (CONFIRM_CYCLES 4 and 1) against a
// behavioural model, with directed opening, random traffic, resets and saturation.
module tb_dl_report_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] vec_a = '0, vec_b = '0;
    logic       ack_a = 1'b0, ack_b = 1'b0;

    logic [1:0] origin_a, origin_b;
    logic       tc_a, tc_b, det_a, det_b, vld_a, vld_b;
    logic [0:0] proc_a, proc_b;
    logic [7:0] cnt_a, cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dl_report_arbiter #(.PROC_NUM(2), .CONFIRM_CYCLES(4)) dut_a (
        .clock          (clock),
        .reset          (reset),
        .dl_in_vec      (vec_a),
        .dl_report_ack  (ack_a),
        .origin         (origin_a),
        .token_clear    (tc_a),
        .dl_detect_out  (det_a),
        .dl_report_vld  (vld_a),
        .dl_report_proc (proc_a),
        .dl_count       (cnt_a)
    );

    dl_report_arbiter #(.PROC_NUM(2), .CONFIRM_CYCLES(1)) dut_b (
        .clock          (clock),
        .reset          (reset),
        .dl_in_vec      (vec_b),
        .dl_report_ack  (ack_b),
        .origin         (origin_b),
        .token_clear    (tc_b),
        .dl_detect_out  (det_b),
        .dl_report_vld  (vld_b),
        .dl_report_proc (proc_b),
        .dl_count       (cnt_b)
    );

    // Reference model: phase 0 waiting, 1 watching a suspect, 2 report outstanding,
    // 3 one-cycle recovery.
    int         phase [2];
    int         suspect [2];
    int         streak [2];
    int         cc_of [2] = '{4, 1};
    logic [1:0] e_origin [2];
    logic       e_tc [2], e_det [2], e_vld [2];
    int         e_proc [2], e_cnt [2];
    logic       prev_tc_a = 1'b0, prev_tc_b = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            phase[m] = 0; suspect[m] = 0; streak[m] = 0;
            e_origin[m] = '0; e_tc[m] = 0; e_det[m] = 0; e_vld[m] = 0;
            e_proc[m] = 0; e_cnt[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input logic [1:0] v, input logic ack);
        logic tc_now;
        tc_now = 1'b0;
        if (phase[m] == 0) begin
            if (v != 0) begin
                suspect[m] = v[0] ? 0 : 1;
                e_origin[m] = 2'(1 << suspect[m]);
                streak[m] = 1;
                phase[m] = 1;
            end
        end else if (phase[m] == 1) begin
            if (v[suspect[m]]) begin
                streak[m]++;
                if (streak[m] > cc_of[m]) begin
                    phase[m] = 2;
                    e_det[m] = 1; e_vld[m] = 1;
                    e_proc[m] = suspect[m];
                    e_cnt[m] = (e_cnt[m] >= 255) ? 255 : e_cnt[m] + 1;
                end
            end else begin
                tc_now = 1'b1; e_origin[m] = '0; phase[m] = 0;
            end
        end else if (phase[m] == 2) begin
            if (ack) begin
                phase[m] = 3; e_vld[m] = 0; e_det[m] = 0; e_origin[m] = '0; tc_now = 1'b1;
            end
        end else begin
            phase[m] = 0;
        end
        e_tc[m] = tc_now;
    endtask

    task automatic check_all();
        check_val("a_origin", 32'(origin_a), 32'(e_origin[0]));
        check_val("a_token_clear", 32'(tc_a), 32'(e_tc[0]));
        check_val("a_detect", 32'(det_a), 32'(e_det[0]));
        check_val("a_vld", 32'(vld_a), 32'(e_vld[0]));
        check_val("a_proc", 32'(proc_a), 32'(e_proc[0]));
        check_val("a_count", 32'(cnt_a), 32'(e_cnt[0]));
        check_val("b_origin", 32'(origin_b), 32'(e_origin[1]));
        check_val("b_token_clear", 32'(tc_b), 32'(e_tc[1]));
        check_val("b_detect", 32'(det_b), 32'(e_det[1]));
        check_val("b_vld", 32'(vld_b), 32'(e_vld[1]));
        check_val("b_proc", 32'(proc_b), 32'(e_proc[1]));
        check_val("b_count", 32'(cnt_b), 32'(e_cnt[1]));
        check_val("a_tc_twice", 32'(tc_a & prev_tc_a), 32'd0);
        check_val("b_tc_twice", 32'(tc_b & prev_tc_b), 32'd0);
        check_val("a_origin_onehot0", 32'($onehot0(origin_a)), 32'd1);
        prev_tc_a = tc_a;
        prev_tc_b = tc_b;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_origin"}, 32'({origin_a, origin_b}), 32'd0);
        check_val({tag, "_flags"}, 32'({tc_a, det_a, vld_a, tc_b, det_b, vld_b}), 32'd0);
        check_val({tag, "_proc"}, 32'({proc_a, proc_b}), 32'd0);
        check_val({tag, "_count"}, 32'({cnt_a, cnt_b}), 32'd0);
    endtask

    initial begin
        bit done_rst_c = 0, done_rst_r = 0;
        model_reset();
        #1 check_zero("reset");
        #1 reset = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            // Stimulus for instance a: directed opening, then random.
            if (c < 35) begin
                if (c <= 16)      vec_a = 2'b10;
                else if (c <= 19) vec_a = 2'b00;
                else if (c <= 22) vec_a = 2'b01;
                else if (c == 23) vec_a = 2'b00;
                else if (c <= 25) vec_a = 2'b10;
                else if (c == 26) vec_a = 2'b00;
                else if (c <= 32) vec_a = 2'b11;
                else              vec_a = 2'b00;
                ack_a = (c == 16 || c == 33);
            end else begin
                vec_a = vec_a ^ {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)};
                ack_a = ($urandom_range(0, 3) == 0);
            end
            // Instance b: random, then a steady detect/ack stream to reach saturation.
            if (c < 400) begin
                vec_b = vec_b ^ {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)};
                ack_b = ($urandom_range(0, 2) == 0);
            end else begin
                vec_b = 2'b01;
                ack_b = 1'b1;
            end

            @(posedge clock);
            model_step(0, vec_a, ack_a);
            model_step(1, vec_b, ack_b);
            #1;
            check_all();
            $display("cycle %0d: a vec=%b ack=%b origin=%b det=%b vld=%b cnt=%0d | b vec=%b cnt=%0d",
                     c, vec_a, ack_a, origin_a, det_a, vld_a, cnt_a, vec_b, cnt_b);

            case (c)
                0:  check_val("r031_origin", 32'(origin_a), 32'h2);
                4:  begin
                        check_val("r031_detect", 32'(det_a), 32'd1);
                        check_val("r031_vld", 32'(vld_a), 32'd1);
                        check_val("r031_proc", 32'(proc_a), 32'd1);
                        check_val("r031_count", 32'(cnt_a), 32'd1);
                    end
                14: check_val("r034_vld_held", 32'({vld_a, det_a, proc_a}), 32'h7);
                16: check_val("r034_after_ack", 32'({vld_a, tc_a, det_a}), 32'h2);
                17: check_val("r034_idle", 32'({tc_a, origin_a}), 32'h0);
                23: check_val("r033_abort", 32'({tc_a, origin_a}), 32'h4);
                24: check_val("r033_new_cand", 32'({tc_a, origin_a}), 32'h2);
                27: check_val("r032_origin", 32'(origin_a), 32'h1);
                31: check_val("r032_proc_count", 32'({proc_a, cnt_a}), 32'h002);
                default: ;
            endcase

            // Asynchronous reset in the middle of a cycle, once while confirming and once
            // while a report is outstanding.
            if (c < 400 && c > 40 &&
                ((!done_rst_c && phase[0] == 1) || (done_rst_c && !done_rst_r && phase[0] == 2))) begin
                #2 reset = 1'b0;
                #1 check_zero(done_rst_c ? "r035_report" : "r035_confirm");
                if (done_rst_c) done_rst_r = 1; else done_rst_c = 1;
                model_reset();
                prev_tc_a = 1'b0;
                prev_tc_b = 1'b0;
                #2 reset = 1'b1;
            end
        end
        check_val("r036_saturated", 32'(cnt_b), 32'd255);
        check_val("r035_both_resets_hit", 32'({done_rst_c, done_rst_r}), 32'h3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
